// File: rtl/bank_port_arbiter.sv
// Shares one single-port data bank between a CPU port and the engine read port.
// Optional CPU write guard while the engine runs: define ARB_WRITE_GUARD_EN.
module bank_port_arbiter #(
  parameter int Amba_Word       = 16,
  parameter int Amba_Addr_Depth = 20
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cpu_req,
  input  logic                       cpu_we,
  input  logic [Amba_Addr_Depth:0]   cpu_addr,
  input  logic [Amba_Word-1:0]       cpu_wdata,
  output logic                       cpu_ack,
  output logic [Amba_Word-1:0]       cpu_rdata,
  output logic                       cpu_err,
  input  logic                       eng_req,
  input  logic [Amba_Addr_Depth:0]   eng_addr,
  input  logic                       eng_active,
  output logic                       eng_gnt,
  output logic                       eng_rvalid,
  output logic [Amba_Word-1:0]       eng_rdata,
  output logic                       bank_we,
  output logic [Amba_Addr_Depth:0]   bank_addr,
  output logic [Amba_Word-1:0]       bank_wdata,
  input  logic [Amba_Word-1:0]       bank_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    CPU_PEND,
    CPU_ACK
  } state_t;

  state_t                     state;
  logic                       cpu_gnt;
  logic                       cpu_rd_q;
  logic                       wr_block;
  logic [Amba_Addr_Depth:0]   last_addr;

  assign cpu_gnt = !rst && (state == IDLE) && cpu_req;
  assign eng_gnt = !rst && eng_req && !cpu_gnt;

`ifdef ARB_WRITE_GUARD_EN
  logic err_q;
  assign wr_block = eng_active;
  assign cpu_err  = err_q;

  always_ff @(posedge clk) begin
    if (rst)
      err_q <= 1'b0;
    else if (cpu_gnt && cpu_we && wr_block)
      err_q <= 1'b1;
  end
`else
  assign wr_block = 1'b0 & eng_active;
  assign cpu_err  = 1'b0;
`endif

  assign bank_we    = cpu_gnt && cpu_we && !wr_block;
  assign bank_wdata = cpu_wdata;
  assign eng_rdata  = bank_rdata;

  // Idle cycles keep the bank address stable at its last value.
  always_comb begin
    bank_addr = last_addr;
    if (cpu_gnt)
      bank_addr = cpu_addr;
    else if (eng_gnt)
      bank_addr = eng_addr;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cpu_ack    <= 1'b0;
      cpu_rdata  <= '0;
      cpu_rd_q   <= 1'b0;
      eng_rvalid <= 1'b0;
      last_addr  <= '0;
    end else begin
      eng_rvalid <= eng_gnt;
      last_addr  <= bank_addr;
      cpu_ack    <= 1'b0;
      case (state)
        IDLE: begin
          if (cpu_gnt) begin
            state    <= CPU_PEND;
            cpu_rd_q <= !cpu_we;
          end
        end
        CPU_PEND: begin
          state   <= CPU_ACK;
          cpu_ack <= 1'b1;
          if (cpu_rd_q)
            cpu_rdata <= bank_rdata;
        end
        CPU_ACK: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
